// File: rtl/alu_sched_pkg.sv
// alu_sched_pkg: shared encodings for the round-robin ALU scheduler
package alu_sched_pkg;
    typedef enum logic {ST_IDLE, ST_EXEC} state_t;
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_AND = 2'b11;
    localparam int RW_DEF = 8;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-input round-robin arbiter, pointer breaks ties
module rr_arb2 (
    input  logic [1:0] eligible,
    input  logic       pointer,
    output logic [1:0] grant,
    output logic       idx
);
    always_comb begin
        idx   = (&eligible) ? pointer : eligible[1];
        grant = (|eligible) ? (2'b01 << idx) : 2'b00;
    end
endmodule

// File: rtl/alu_rr_scheduler.sv
// alu_rr_scheduler: shares one fixed-latency ALU between two channels with round-robin grants
module alu_rr_scheduler
    import alu_sched_pkg::*;
#(
    parameter int ALU_LAT = 1,
    parameter int RW      = RW_DEF
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic [1:0]    req_valid_i,
    output logic [1:0]    req_ready_o,
    input  logic [3:0]    req_a0_i,
    input  logic [3:0]    req_b0_i,
    input  logic [1:0]    req_sel0_i,
    input  logic [3:0]    req_a1_i,
    input  logic [3:0]    req_b1_i,
    input  logic [1:0]    req_sel1_i,
    output logic [3:0]    alu_a_o,
    output logic [3:0]    alu_b_o,
    output logic [1:0]    alu_sel_o,
    output logic          alu_start_o,
    input  logic [RW-1:0] alu_y_i,
    output logic [1:0]    rsp_valid_o,
    input  logic [1:0]    rsp_ready_i,
    output logic [RW-1:0] rsp_data0_o,
    output logic [RW-1:0] rsp_data1_o,
    output logic          busy_o,
    output logic          grant_o
);
    if (ALU_LAT < 1 || ALU_LAT > 7) begin : g_bad_lat
        $error("ALU_LAT must be in 1..7");
    end

    localparam logic [2:0] CNT_INIT = 3'(ALU_LAT - 1);

    state_t        state_q, state_d;
    logic          rr_q, rr_d, grant_q, grant_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [3:0]    a_q, a_d, b_q, b_d;
    logic [1:0]    sel_q, sel_d, rsp_valid_q, rsp_valid_d;
    logic [RW-1:0] data0_q, data0_d, data1_q, data1_d;
    logic [1:0]    eligible, arb_grant;
    logic          arb_idx;

    // A slot being drained this cycle already counts as free
    assign eligible = req_valid_i & (~rsp_valid_q | rsp_ready_i) & {2{state_q == ST_IDLE}};

    rr_arb2 u_arb (
        .eligible(eligible),
        .pointer (rr_q),
        .grant   (arb_grant),
        .idx     (arb_idx)
    );

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        grant_d     = grant_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        sel_d       = sel_q;
        data0_d     = data0_q;
        data1_d     = data1_q;
        rsp_valid_d = rsp_valid_q & ~rsp_ready_i;
        if (state_q == ST_IDLE && |eligible) begin
            state_d = ST_EXEC;
            a_d     = arb_idx ? req_a1_i : req_a0_i;
            b_d     = arb_idx ? req_b1_i : req_b0_i;
            sel_d   = arb_idx ? req_sel1_i : req_sel0_i;
            grant_d = arb_idx;
            rr_d    = ~arb_idx;
            cnt_d   = CNT_INIT;
        end else if (state_q == ST_EXEC) begin
            if (cnt_q == 3'd0) begin
                state_d              = ST_IDLE;
                rsp_valid_d[grant_q] = 1'b1;
                data0_d              = grant_q ? data0_q : alu_y_i;
                data1_d              = grant_q ? alu_y_i : data1_q;
            end else begin
                cnt_d = cnt_q - 3'd1;
            end
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q     <= ST_IDLE;
            rr_q        <= 1'b0;
            grant_q     <= 1'b0;
            cnt_q       <= 3'd0;
            a_q         <= 4'd0;
            b_q         <= 4'd0;
            sel_q       <= 2'd0;
            rsp_valid_q <= 2'd0;
            data0_q     <= '0;
            data1_q     <= '0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            grant_q     <= grant_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sel_q       <= sel_d;
            rsp_valid_q <= rsp_valid_d;
            data0_q     <= data0_d;
            data1_q     <= data1_d;
        end
    end

    assign req_ready_o = arb_grant;
    assign alu_a_o     = a_q;
    assign alu_b_o     = b_q;
    assign alu_sel_o   = sel_q;
    assign alu_start_o = (state_q == ST_EXEC) && (cnt_q == CNT_INIT);
    assign busy_o      = state_q == ST_EXEC;
    assign grant_o     = grant_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data0_o = data0_q;
    assign rsp_data1_o = data1_q;
endmodule

// File: tb/tb_alu_rr_scheduler.sv
// tb_alu_rr_scheduler: two DUTs (latency 1 and 3) on shared stimulus, checked against a timestamp model
module tb_alu_rr_scheduler;
    localparam int LAT0 = 1;
    localparam int LAT1 = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req_valid, rsp_ready, s0, s1;
    logic [3:0] a0, b0, a1, b1;

    logic [1:0] ready_w[2], rv_w[2], sel_w[2];
    logic [3:0] a_w[2], b_w[2];
    logic       start_w[2], busy_w[2], grant_w[2];
    logic [7:0] d0_w[2], d1_w[2], y_w[2];

    int total = 0;
    int bad = 0;
    int cyc = 0;

    logic       m_active[2], m_ch[2], m_rr[2], m_grant[2];
    int         m_tacc[2];
    logic [3:0] m_a[2], m_b[2];
    logic [1:0] m_sel[2], m_rv[2];
    logic [7:0] m_d0[2], m_d1[2];

    always #5 clk = ~clk;

    function automatic logic [7:0] alu(input logic [3:0] a, input logic [3:0] b, input logic [1:0] s);
        logic [7:0] xa, xb;
        xa = {4'b0, a};
        xb = {4'b0, b};
        return s == 2'b00 ? xa + xb : s == 2'b01 ? xa - xb : s == 2'b10 ? xa * xb : (xa & xb);
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        alu_rr_scheduler #(.ALU_LAT(g == 0 ? LAT0 : LAT1), .RW(8)) u_dut (
            .wb_clk_i   (clk),
            .wb_rst_i   (rst),
            .req_valid_i(req_valid),
            .req_ready_o(ready_w[g]),
            .req_a0_i   (a0),
            .req_b0_i   (b0),
            .req_sel0_i (s0),
            .req_a1_i   (a1),
            .req_b1_i   (b1),
            .req_sel1_i (s1),
            .alu_a_o    (a_w[g]),
            .alu_b_o    (b_w[g]),
            .alu_sel_o  (sel_w[g]),
            .alu_start_o(start_w[g]),
            .alu_y_i    (y_w[g]),
            .rsp_valid_o(rv_w[g]),
            .rsp_ready_i(rsp_ready),
            .rsp_data0_o(d0_w[g]),
            .rsp_data1_o(d1_w[g]),
            .busy_o     (busy_w[g]),
            .grant_o    (grant_w[g])
        );
        assign y_w[g] = alu(a_w[g], b_w[g], sel_w[g]);
    end

    function automatic logic [1:0] elig_f(input int k);
        return req_valid & (~m_rv[k] | rsp_ready);
    endfunction

    function automatic logic pick_f(input int k);
        return elig_f(k) == 2'b11 ? m_rr[k] : elig_f(k) == 2'b10;
    endfunction

    function automatic logic fin_f(input int k);
        return m_active[k] && cyc == m_tacc[k] + (k == 0 ? LAT0 : LAT1);
    endfunction

    function automatic logic [1:0] exp_ready(input int k);
        return (m_active[k] || elig_f(k) == 2'b00) ? 2'b00 : (pick_f(k) ? 2'b10 : 2'b01);
    endfunction

    // Model: an accepted op occupies cycles tacc+1..tacc+lat and its result lands at the end of the last one
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                m_active[k] <= 1'b0;
                m_ch[k]     <= 1'b0;
                m_rr[k]     <= 1'b0;
                m_grant[k]  <= 1'b0;
                m_tacc[k]   <= 0;
                m_a[k]      <= 4'd0;
                m_b[k]      <= 4'd0;
                m_sel[k]    <= 2'd0;
                m_rv[k]     <= 2'd0;
                m_d0[k]     <= 8'd0;
                m_d1[k]     <= 8'd0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                m_rv[k] <= (m_rv[k] & ~rsp_ready) | (fin_f(k) ? (m_ch[k] ? 2'b10 : 2'b01) : 2'b00);
                if (fin_f(k) && !m_ch[k]) m_d0[k] <= alu(m_a[k], m_b[k], m_sel[k]);
                if (fin_f(k) && m_ch[k]) m_d1[k] <= alu(m_a[k], m_b[k], m_sel[k]);
                if (fin_f(k)) m_active[k] <= 1'b0;
                else if (!m_active[k] && elig_f(k) != 2'b00) begin
                    m_active[k] <= 1'b1;
                    m_tacc[k]   <= cyc;
                    m_ch[k]     <= pick_f(k);
                    m_grant[k]  <= pick_f(k);
                    m_rr[k]     <= !pick_f(k);
                    m_a[k]      <= pick_f(k) ? a1 : a0;
                    m_b[k]      <= pick_f(k) ? b1 : b0;
                    m_sel[k]    <= pick_f(k) ? s1 : s0;
                end
            end
            cyc <= cyc + 1;
        end
    end

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s inst%0d got=%0h exp=%0h t=%0t", nm, k, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            chk("ready", k, ready_w[k], exp_ready(k));
            chk("busy", k, busy_w[k], m_active[k]);
            chk("start", k, start_w[k], m_active[k] && cyc == m_tacc[k] + 1);
            chk("alu_a", k, a_w[k], m_a[k]);
            chk("alu_b", k, b_w[k], m_b[k]);
            chk("alu_sel", k, sel_w[k], m_sel[k]);
            chk("grant", k, grant_w[k], m_grant[k]);
            chk("rsp_valid", k, rv_w[k], m_rv[k]);
            chk("rsp_data0", k, d0_w[k], m_d0[k]);
            chk("rsp_data1", k, d1_w[k], m_d1[k]);
        end
    end

    task automatic go();
        @(posedge clk);
        #2;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        go();
        rst = 1'b1;
        req_valid = 2'b00;
        go();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0] pat[8];
        int starts;
        pat = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
        rst = 1'b1;
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        {a0, b0, a1, b1} = '0;
        {s0, s1} = '0;
        repeat (2) go();
        rst = 1'b0;
        repeat (20) go();
        mid();
        for (int k = 0; k < 2; k++) begin
            chk("idle_busy", k, busy_w[k], 0);
            chk("idle_rv", k, rv_w[k], 0);
            chk("idle_a", k, a_w[k], 0);
        end

        go();
        a0 = 4'h9; b0 = 4'h9; s0 = 2'b00; req_valid = 2'b01;
        mid();
        chk("t2_ready", 0, ready_w[0], 2'b01);
        go();
        req_valid = 2'b00;
        mid();
        chk("t2_alu_a", 0, a_w[0], 4'h9);
        chk("t2_start", 0, start_w[0], 1);
        chk("t2_start", 1, start_w[1], 1);
        go();
        mid();
        chk("t2_rv", 0, rv_w[0], 2'b01);
        chk("t2_d0", 0, d0_w[0], 8'h12);
        go();
        go();
        mid();
        chk("t2_rv", 1, rv_w[1], 2'b01);
        chk("t2_d0", 1, d0_w[1], 8'h12);

        do_reset();
        a0 = 4'd1; b0 = 4'd2; a1 = 4'd3; b1 = 4'd4; req_valid = 2'b11;
        for (int i = 0; i < 8; i++) begin
            mid();
            chk("t3_ready", 0, ready_w[0], pat[i]);
            if (i == 2) chk("t3_d0", 0, d0_w[0], 8'h03);
            if (i == 4) chk("t3_d1", 0, d1_w[0], 8'h07);
            go();
        end
        req_valid = 2'b00;

        do_reset();
        rsp_ready = 2'b10; a0 = 4'd5; b0 = 4'd6; req_valid = 2'b01;
        mid();
        chk("t4_acc0", 0, ready_w[0], 2'b01);
        go();
        req_valid = 2'b00;
        go();
        a1 = 4'd2; b1 = 4'd2; req_valid = 2'b11;
        mid();
        chk("t4_only1", 0, ready_w[0], 2'b10);
        chk("t4_pend", 0, rv_w[0], 2'b01);
        go();
        req_valid = 2'b01;
        go();
        mid();
        chk("t4_blocked", 0, ready_w[0], 2'b00);
        chk("t4_rv", 0, rv_w[0], 2'b11);
        go();
        rsp_ready = 2'b11;
        mid();
        chk("t4_drain_acc", 0, ready_w[0], 2'b01);
        chk("t4_d0", 0, d0_w[0], 8'h0b);
        go();
        req_valid = 2'b00;
        repeat (4) go();

        do_reset();
        a1 = 4'hF; b1 = 4'h1; s1 = 2'b00; req_valid = 2'b10;
        mid();
        chk("t5_ready", 1, ready_w[1], 2'b10);
        starts = 0;
        for (int j = 1; j <= 5; j++) begin
            go();
            if (j == 1) req_valid = 2'b00;
            mid();
            starts += int'(start_w[1]);
            chk("t5_busy", 1, busy_w[1], j <= 3);
            if (j == 4) begin
                chk("t5_rv", 1, rv_w[1], 2'b10);
                chk("t5_d1", 1, d1_w[1], 8'h10);
            end
        end
        chk("t5_starts", 1, starts, 1);

        do_reset();
        a0 = 4'd5; b0 = 4'd1; req_valid = 2'b01;
        go();
        req_valid = 2'b00;
        go();
        mid();
        chk("t6_busy_pre", 1, busy_w[1], 1);
        rst = 1'b1;
        #1;
        chk("t6_busy_rst", 1, busy_w[1], 0);
        chk("t6_a_rst", 1, a_w[1], 0);
        chk("t6_rv_rst", 0, rv_w[0], 0);
        go();
        go();
        mid();
        chk("t6_no_rsp", 1, rv_w[1], 0);
        go();
        rst = 1'b0;
        req_valid = 2'b11;
        mid();
        chk("t6_first", 0, ready_w[0], 2'b01);
        chk("t6_first", 1, ready_w[1], 2'b01);
        go();
        req_valid = 2'b00;
        repeat (5) go();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
